rgb_pwm_dimmer: RTL and testbench

- Output stage between the 6-bit RGB decoder output and the two board RGB LEDs (led4, led5).
- Gates each decoder on/off bit with a shared PWM waveform so the lit colours can be dimmed.
- Brightness is stepped up and down by two raw push-buttons.
- Includes on-chip synchronisation and debounce, and applies new decoder values only at PWM period boundaries to avoid glitches.

---
 rtl/rgb_pwm_dimmer.sv | 150 +++++++++++++++
 tb/tb_rgb_pwm_dimmer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_dimmer.sv
// PWM dimmer between the RGB decoder and the two board LEDs, with debounced brightness buttons.
// Optional triangle "breathe" mode is enabled by defining RGB_PWM_BREATHE_EN.
module rgb_pwm_dimmer #(
    parameter int PWM_W           = 8,
    parameter int PRESCALE        = 16,
    parameter int STEP            = 16,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BRIGHT_RESET    = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       rgb_on,
    input  logic             btn_up,
    input  logic             btn_dn,
`ifdef RGB_PWM_BREATHE_EN
    input  logic             breathe,
`endif
    output logic [5:0]       led,
    output logic [PWM_W-1:0] bright,
    output logic             period_start
);
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PWM_W-1:0] PWM_MAX  = {PWM_W{1'b1}};
    localparam logic [PWM_W:0]   MAX_EXT  = {1'b0, {PWM_W{1'b1}}};
    localparam logic [PWM_W:0]   STEP_EXT = (PWM_W+1)'(STEP);

    logic [PS_W-1:0]  presc_reg;
    logic [PWM_W-1:0] pwm_cnt_reg;
    logic [5:0]       rgb_q_reg;
    logic [5:0]       led_reg;
    logic             period_start_reg;
    logic [PWM_W-1:0] bright_reg, bright_next;
    logic             tick, wrap, duty;
    logic [1:0]       btn_raw;
    logic [1:0]       press;
    logic [PWM_W:0]   up_sum;

    assign tick = (presc_reg == PS_W'(PRESCALE - 1));
    assign wrap = tick && (pwm_cnt_reg == PWM_MAX);
    assign duty = (bright_reg == PWM_MAX) || (pwm_cnt_reg < bright_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg        <= '0;
            pwm_cnt_reg      <= '0;
            rgb_q_reg        <= '0;
            led_reg          <= '0;
            period_start_reg <= 1'b0;
        end else begin
            presc_reg        <= tick ? '0 : presc_reg + 1'b1;
            if (tick)
                pwm_cnt_reg  <= pwm_cnt_reg + 1'b1;
            // New colours only take effect at the period boundary to avoid partial pulses.
            if (wrap)
                rgb_q_reg    <= rgb_on;
            period_start_reg <= wrap;
            led_reg          <= rgb_q_reg & {6{duty}};
        end
    end

    assign btn_raw = {btn_dn, btn_up};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_reg, sync2_reg, stable_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             accept;

            assign accept    = (sync2_reg != stable_reg) && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
            // Press fires on the same edge the stable level flips to 1, so bright moves with it.
            assign press[gi] = accept && sync2_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (accept) begin
                        stable_reg <= sync2_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign up_sum = {1'b0, bright_reg} + STEP_EXT;

`ifdef RGB_PWM_BREATHE_EN
    logic dir_up_reg, dir_up_next;
`endif

    always_comb begin
        bright_next = bright_reg;
`ifdef RGB_PWM_BREATHE_EN
        dir_up_next = dir_up_reg;
        if (breathe) begin
            if (period_start_reg) begin
                if (dir_up_reg) begin
                    if (bright_reg == PWM_MAX) begin
                        dir_up_next = 1'b0;
                        bright_next = bright_reg - 1'b1;
                    end else begin
                        bright_next = bright_reg + 1'b1;
                    end
                end else begin
                    if (bright_reg == '0) begin
                        dir_up_next = 1'b1;
                        bright_next = bright_reg + 1'b1;
                    end else begin
                        bright_next = bright_reg - 1'b1;
                    end
                end
            end
        end else
`endif
        if (press[0] && !press[1]) begin
            bright_next = (up_sum > MAX_EXT) ? PWM_MAX : up_sum[PWM_W-1:0];
        end else if (press[1] && !press[0]) begin
            bright_next = ({1'b0, bright_reg} < STEP_EXT) ? '0 : bright_reg - STEP_EXT[PWM_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bright_reg <= PWM_W'(BRIGHT_RESET);
`ifdef RGB_PWM_BREATHE_EN
            dir_up_reg <= 1'b1;
`endif
        end else begin
            bright_reg <= bright_next;
`ifdef RGB_PWM_BREATHE_EN
            dir_up_reg <= dir_up_next;
`endif
        end
    end

    assign led          = led_reg;
    assign bright       = bright_reg;
    assign period_start = period_start_reg;
endmodule

// File: tb/tb_rgb_pwm_dimmer.sv
// Directed bench for rgb_pwm_dimmer with a 16-tick PWM period and 4-cycle debounce.
// Define RGB_PWM_BREATHE_EN on both files to also exercise breathe mode.
module tb_rgb_pwm_dimmer;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] rgb_on;
    logic       btn_up, btn_dn;
    logic [5:0] led;
    logic [3:0] bright;
    logic       period_start;
`ifdef RGB_PWM_BREATHE_EN
    logic       breathe = 1'b0;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    rgb_pwm_dimmer #(
        .PWM_W(4), .PRESCALE(1), .STEP(4), .DEBOUNCE_CYCLES(4), .BRIGHT_RESET(8)
    ) dut (
        .clk(clk), .rst(rst), .rgb_on(rgb_on), .btn_up(btn_up), .btn_dn(btn_dn),
`ifdef RGB_PWM_BREATHE_EN
        .breathe(breathe),
`endif
        .led(led), .bright(bright), .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic press_btn(input bit up, input bit dn);
        btn_up = up;
        btn_dn = dn;
        for (int i = 0; i < 8; i++) tick();
        btn_up = 1'b0;
        btn_dn = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset();
        int  hi, bad;
        bit  ps_seen, led_seen;
        rgb_on = 6'b111111;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        rst    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (led !== 6'd0 || bright !== 4'd8 || period_start !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: led=%b bright=%0d ps=%b, need led=0 bright=8 ps=0", led, bright, period_start);
            end
        end
        rst = 1'b0;
        ps_seen  = 1'b0;
        led_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (period_start) ps_seen = 1'b1;
            if (led !== 6'd0) led_seen = 1'b1;
        end
        n_checks++;
        if (ps_seen || led_seen || bright !== 4'd8) begin
            n_fail++;
            $display("FAIL first_period: ps_seen=%b led_seen=%b bright=%0d, need 0 0 8", ps_seen, led_seen, bright);
        end
        tick();
        n_checks++;
        if (period_start !== 1'b1) begin
            n_fail++;
            $display("FAIL first_wrap: period_start=%b, need 1", period_start);
        end
        hi  = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led === 6'b111111) hi++;
            else if (led !== 6'd0) bad++;
        end
        n_checks++;
        if (hi != 8 || bad != 0) begin
            n_fail++;
            $display("FAIL duty_half: high=%0d other=%0d, need 8 0", hi, bad);
        end
        $display("test_reset done");
    endtask

    task automatic test_latch();
        bit         ok;
        logic [5:0] exp;
        rgb_on = 6'b100001;
        wait_ps(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL latch_wait1: period_start timeout, need pulse");
        end
        for (int p = 0; p < 2; p++) begin
            for (int i = 1; i <= 16; i++) begin
                tick();
                if (p == 0 && i == 5) rgb_on = 6'b010010;
                exp = (i <= 8) ? ((p == 0) ? 6'b100001 : 6'b010010) : 6'd0;
                n_checks++;
                if (led !== exp) begin
                    n_fail++;
                    $display("FAIL latch_p%0d_t%0d: led=%b, need %b", p, i, led, exp);
                end
            end
            n_checks++;
            if (period_start !== 1'b1) begin
                n_fail++;
                $display("FAIL latch_wrap%0d: period_start=%b, need 1", p, period_start);
            end
        end
        $display("test_latch done");
    endtask

    task automatic test_debounce();
        bit ok;
        int bad;
        for (int g = 0; g < 5; g++) begin
            btn_up = 1'b1; tick(); tick();
            btn_up = 1'b0; tick(); tick();
        end
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (bright !== 4'd8) begin
            n_fail++;
            $display("FAIL glitch: bright=%0d, need 8", bright);
        end
        btn_up = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (bright !== 4'd8) begin
            n_fail++;
            $display("FAIL up_early: bright=%0d at 5 clocks, need 8", bright);
        end
        tick();
        n_checks++;
        if (bright !== 4'd12) begin
            n_fail++;
            $display("FAIL up_latency: bright=%0d at 6 clocks, need 12", bright);
        end
        btn_up = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (bright !== 4'd12) begin
            n_fail++;
            $display("FAIL release: bright=%0d, need 12", bright);
        end
        press_btn(1'b1, 1'b0);
        n_checks++;
        if (bright !== 4'd15) begin
            n_fail++;
            $display("FAIL up_sat: bright=%0d, need 15", bright);
        end
        wait_ps(ok);
        bad = ok ? 0 : 100;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led !== 6'b010010) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL full_on: %0d clocks off or timeout, need led=010010 every clock", bad);
        end
        press_btn(1'b1, 1'b0);
        n_checks++;
        if (bright !== 4'd15) begin
            n_fail++;
            $display("FAIL up_sat_again: bright=%0d, need 15", bright);
        end
        $display("test_debounce done");
    endtask

    task automatic test_down();
        bit ok1, ok2;
        int bad;
        apply_reset();
        press_btn(1'b0, 1'b1);
        n_checks++;
        if (bright !== 4'd4) begin
            n_fail++;
            $display("FAIL dn_step: bright=%0d, need 4", bright);
        end
        press_btn(1'b0, 1'b1);
        n_checks++;
        if (bright !== 4'd0) begin
            n_fail++;
            $display("FAIL dn_zero: bright=%0d, need 0", bright);
        end
        press_btn(1'b0, 1'b1);
        n_checks++;
        if (bright !== 4'd0) begin
            n_fail++;
            $display("FAIL dn_sat: bright=%0d, need 0", bright);
        end
        rgb_on = 6'b111111;
        wait_ps(ok1);
        wait_ps(ok2);
        bad = (ok1 && ok2) ? 0 : 100;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led !== 6'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL dark: %0d lit clocks or timeout, need led=0", bad);
        end
        $display("test_down done");
    endtask

    task automatic test_simultaneous();
        apply_reset();
        press_btn(1'b1, 1'b1);
        n_checks++;
        if (bright !== 4'd8) begin
            n_fail++;
            $display("FAIL both_press: bright=%0d, need 8", bright);
        end
        press_btn(1'b1, 1'b0);
        n_checks++;
        if (bright !== 4'd12) begin
            n_fail++;
            $display("FAIL pre_reset_up: bright=%0d, need 12", bright);
        end
        btn_dn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst    = 1'b1;
        btn_dn = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bright !== 4'd8) begin
            n_fail++;
            $display("FAIL mid_deb_reset: bright=%0d, need 8", bright);
        end
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (bright !== 4'd8) begin
            n_fail++;
            $display("FAIL no_ghost_press: bright=%0d, need 8", bright);
        end
        $display("test_simultaneous done");
    endtask

`ifdef RGB_PWM_BREATHE_EN
    task automatic test_breathe();
        bit ok;
        int exp;
        bit dir_up;
        apply_reset();
        press_btn(1'b1, 1'b0);
        btn_up  = 1'b1;
        breathe = 1'b1;
        exp     = 12;
        dir_up  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wait_ps(ok);
            tick();
            if (dir_up) begin
                if (exp == 15) begin dir_up = 1'b0; exp = 14; end
                else exp = exp + 1;
            end else begin
                if (exp == 0) begin dir_up = 1'b1; exp = 1; end
                else exp = exp - 1;
            end
            n_checks++;
            if (!ok || bright !== 4'(exp)) begin
                n_fail++;
                $display("FAIL breathe_step%0d: bright=%0d ok=%b, need %0d", k, bright, ok, exp);
            end
        end
        breathe = 1'b0;
        wait_ps(ok);
        wait_ps(ok);
        btn_up = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (bright !== 4'(exp)) begin
            n_fail++;
            $display("FAIL breathe_freeze: bright=%0d, need %0d", bright, exp);
        end
        $display("test_breathe done");
    endtask
`endif

    initial begin
        test_reset();
        test_latch();
        test_debounce();
        test_down();
        test_simultaneous();
`ifdef RGB_PWM_BREATHE_EN
        test_breathe();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
